monitoreo_sensor_lector: RTL and testbench
==========================================

Name: monitoreo_sensor_lector

Overview:
- Produces the temperature stream consumed by `monitoreo_top` on `temp_entrada`, i.e. the producer end of that interface.
- Periodically reads a serial temperature sensor through a 3-wire SPI mode-0 link: the block drives `sensor_cs_n` and `sensor_sclk` and samples `sensor_miso`.
- Checks each frame, then registers and holds the temperature, in units of 0.1 °C, for the monitor.
- Bad frames raise an error flag and never disturb the held value.

Parameters:
- TEMP_W, 10, width of the temperature field and of `temp_salida`.
- CLK_DIV, 4, number of clk cycles per sclk half-period (≥1).
- FRAME_BITS, 16, bits per sensor frame (fixed layout, see Behaviour).
- SAMPLE_PERIOD, 1000, number of clk cycles between successive `cs_n` falling edges. Elaboration check: SAMPLE_PERIOD ≥ 2*CLK_DIV*(FRAME_BITS+1)+4.
- TEMP_DEFAULT, 220, value of `temp_salida` after reset (22.0 °C, inside the 180..259 normal band).

Ports:
- clk  in  1  system clock.
- arst_n  in  1  reset, synchronous, active-low.
- habilitar  in  1  enables periodic acquisition.
- sensor_miso  in  1  serial data from the sensor, MSB first.
- sensor_sclk  out  1  serial clock, idles low.
- sensor_cs_n  out  1  chip select, idles high.
- temp_salida  out  TEMP_W  last valid temperature; connects to `temp_entrada` of the monitor.
- temp_valida  out  1  one-cycle pulse when `temp_salida` updates.
- error_sensor  out  1  set on a bad frame; cleared on the next good frame.
- contador_muestras  out  16  count of good frames, wraps 65535→0.

Behaviour:
- Reset is synchronous and active-low. It is sampled on the clk rising edge and overrides everything, including a transfer in progress. Values after the reset edge:
  - sensor_cs_n=1, sensor_sclk=0
  - temp_salida=TEMP_DEFAULT, temp_valida=0
  - error_sensor=0, contador_muestras=0
  - FSM in REPOSO, all counters cleared.
- FSM states: REPOSO, ESPERA, SELECCION, TRANSFERENCIA, FIN.
- REPOSO: cs_n=1.
  - If habilitar=1, go to SELECCION on the next cycle and restart the period counter.
- SELECCION: cs_n=0, sclk=0 for CLK_DIV cycles, giving the sensor setup time for bit 15. Then go to TRANSFERENCIA.
- TRANSFERENCIA: sclk toggles every CLK_DIV cycles, starting low.
  - `sensor_miso` is captured into the shift register on the clk edge that drives sclk 0→1.
  - After the FRAME_BITS-th capture, sclk completes its high phase, returns low, and the FSM goes to FIN.
- FIN (1 cycle): cs_n=1, frame checked. On the following edge temp_salida, temp_valida, error_sensor and contador_muestras update together.
  - Latency: cs_n rise → temp_valida high is 1 clk.
- ESPERA: cs_n=1 until the period counter reaches SAMPLE_PERIOD-1, measured from the previous cs_n fall. Then:
  - go to SELECCION if habilitar=1;
  - otherwise go to REPOSO.
- habilitar deasserted mid-frame: the current frame completes normally and is checked. The FSM then returns to REPOSO instead of starting a new period.
- Frame layout, bit 15 first:
  - [15] start marker, must be 0.
  - [14:5] temperature, unsigned, TEMP_W bits.
  - [4:1] reserved, must be 0.
  - [0] even parity: XOR of [15:0] must equal 0.
- Good frame: marker=0, reserved=0, parity ok, and temperature ≠ all-ones (all-ones means the sensor is disconnected). On a good frame:
  - temp_salida ← field;
  - temp_valida pulses;
  - error_sensor ← 0;
  - contador_muestras increments.
- Bad frame: temp_salida holds, temp_valida stays 0, error_sensor ← 1, contador_muestras holds.
- temp_valida is never high for two consecutive cycles.
- sclk and cs_n are glitch-free register outputs.

Decomposition:
- Add to `monitoreo_pkg`:
  - enum `estado_lector_t` (REPOSO, ESPERA, SELECCION, TRANSFERENCIA, FIN);
  - constants for the frame field positions (BIT_MARCA=15, TEMP_MSB=14, TEMP_LSB=5, RES_MSB=4, RES_LSB=1, BIT_PARIDAD=0);
  - TEMP_DESCONECTADO = all-ones.
- One sub-module, `monitoreo_sclk_div`: a CLK_DIV divider that emits `tick_subida` and `tick_bajada` strobes and holds the sclk register. It is enabled only in TRANSFERENCIA.

Test Plan:
- Reset, habilitar=1, sensor model returns frame with temp=220 and correct parity → cs_n falls 1 cycle after reset release; 16 sclk rising edges; temp_valida pulse 1 cycle after cs_n rises; temp_salida=220; contador_muestras=1; error_sensor=0.
- Frames with temp 179 then 260 → temp_salida=179, then 260 one SAMPLE_PERIOD later; cs_n falling edges exactly 1000 clk apart.
- Frame temp=300 with parity bit flipped → error_sensor=1, temp_salida holds its prior value, no temp_valida; next good frame temp=250 → error_sensor=0, temp_salida=250.
- Frame with start marker=1, then frame temp=1023 → both flagged error_sensor=1; contador_muestras unchanged.
- habilitar dropped at 8th sclk rise → frame completes and updates; FSM goes to REPOSO; no further cs_n fall over 3×SAMPLE_PERIOD.
- arst_n low at 5th sclk rise → next edge cs_n=1, sclk=0, temp_salida=220; after release a fresh full 16-bit frame is read.

Source files
------------

// File: rtl/monitoreo_pkg.sv
// rtl/monitoreo_pkg.sv - shared FSM type, sensor frame layout and frame check
package monitoreo_pkg;

  typedef enum logic [2:0] {
    REPOSO,
    ESPERA,
    SELECCION,
    TRANSFERENCIA,
    FIN
  } estado_lector_t;

  localparam int TRAMA_W     = 16;
  localparam int BIT_MARCA   = 15;
  localparam int TEMP_MSB    = 14;
  localparam int TEMP_LSB    = 5;
  localparam int RES_MSB     = 4;
  localparam int RES_LSB     = 1;
  localparam int BIT_PARIDAD = 0;
  localparam int TEMP_BITS   = TEMP_MSB - TEMP_LSB + 1;

  // All-ones temperature is what a disconnected sensor reads back as.
  localparam logic [TEMP_BITS-1:0] TEMP_DESCONECTADO = '1;

  function automatic logic trama_valida(input logic [TRAMA_W-1:0] t);
    logic paridad_ok;
    paridad_ok = ((^t[TRAMA_W-1:1]) ^ t[BIT_PARIDAD]) == 1'b0;
    return (t[BIT_MARCA] == 1'b0) && (t[RES_MSB:RES_LSB] == '0) && paridad_ok
           && (t[TEMP_MSB:TEMP_LSB] != TEMP_DESCONECTADO);
  endfunction

endpackage

// File: rtl/monitoreo_sensor_lector_if.sv
// rtl/monitoreo_sensor_lector_if.sv - 3-wire SPI link between lector and sensor
interface monitoreo_sensor_lector_if;
  logic sensor_sclk;
  logic sensor_cs_n;
  logic sensor_miso;

  modport master (output sensor_sclk, output sensor_cs_n, input sensor_miso);
  modport slave  (input sensor_sclk, input sensor_cs_n, output sensor_miso);
endinterface

// File: rtl/monitoreo_sclk_div.sv
// rtl/monitoreo_sclk_div.sv - sclk register with rise/fall strobes every CLK_DIV cycles
module monitoreo_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  output logic sclk,
  output logic tick_subida,
  output logic tick_bajada
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic             fin_medio;

  // Strobes mark the clk edge on which sclk will toggle.
  assign fin_medio   = en && (cnt == DIV_MAX);
  assign tick_subida = fin_medio && !sclk;
  assign tick_bajada = fin_medio && sclk;

  always_ff @(posedge clk) begin
    if (!arst_n || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (cnt == DIV_MAX) begin
      cnt  <= '0;
      sclk <= !sclk;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/monitoreo_sensor_lector.sv
// rtl/monitoreo_sensor_lector.sv - periodic SPI temperature reader feeding the monitor
module monitoreo_sensor_lector
  import monitoreo_pkg::*;
#(
  parameter int TEMP_W        = 10,
  parameter int CLK_DIV       = 4,
  parameter int FRAME_BITS    = 16,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TEMP_DEFAULT  = 220
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       habilitar,
  monitoreo_sensor_lector_if.master  spi,
  output logic [TEMP_W-1:0]          temp_salida,
  output logic                       temp_valida,
  output logic                       error_sensor,
  output logic [15:0]                contador_muestras
);
  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam logic [PER_W-1:0] PER_MAX  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [PER_W-1:0] SEL_MAX  = PER_W'(CLK_DIV - 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_W-1:0] BITS_MAX = BIT_W'(FRAME_BITS);

  generate
    if (CLK_DIV < 1 || SAMPLE_PERIOD < 2 * CLK_DIV * (FRAME_BITS + 1) + 4) begin : g_chk
      $error("monitoreo_sensor_lector: SAMPLE_PERIOD too short for one frame");
    end
  endgenerate

  estado_lector_t          estado, estado_sig;
  logic [PER_W-1:0]        cnt_periodo;
  logic [BIT_W-1:0]        cnt_bits;
  logic [FRAME_BITS-1:0]   trama;
  logic                    cs_n;
  logic                    sclk;
  logic                    tick_subida;
  logic                    tick_bajada;
  logic                    reinicia_periodo;

  assign spi.sensor_cs_n = cs_n;
  assign spi.sensor_sclk = sclk;

  monitoreo_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .clk         (clk),
    .arst_n      (arst_n),
    .en          (estado == TRANSFERENCIA),
    .sclk        (sclk),
    .tick_subida (tick_subida),
    .tick_bajada (tick_bajada)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) estado <= REPOSO;
    else         estado <= estado_sig;
  end

  always_comb begin
    estado_sig       = estado;
    reinicia_periodo = 1'b0;
    case (estado)
      REPOSO:
        if (habilitar) begin
          estado_sig       = SELECCION;
          reinicia_periodo = 1'b1;
        end
      ESPERA:
        if (cnt_periodo == PER_MAX) begin
          if (habilitar) begin
            estado_sig       = SELECCION;
            reinicia_periodo = 1'b1;
          end else begin
            estado_sig = REPOSO;
          end
        end
      SELECCION:
        if (cnt_periodo == SEL_MAX) estado_sig = TRANSFERENCIA;
      TRANSFERENCIA:
        if (tick_bajada && cnt_bits == BITS_MAX) estado_sig = FIN;
      FIN:
        estado_sig = habilitar ? ESPERA : REPOSO;
      default:
        estado_sig = REPOSO;
    endcase
  end

  // cs_n is registered from the next state so it moves on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cs_n              <= 1'b1;
      cnt_periodo       <= '0;
      cnt_bits          <= '0;
      trama             <= '0;
      temp_salida       <= TEMP_W'(TEMP_DEFAULT);
      temp_valida       <= 1'b0;
      error_sensor      <= 1'b0;
      contador_muestras <= '0;
    end else begin
      cs_n        <= !(estado_sig inside {SELECCION, TRANSFERENCIA});
      temp_valida <= 1'b0;

      if (reinicia_periodo)      cnt_periodo <= '0;
      else if (estado != REPOSO) cnt_periodo <= cnt_periodo + PER_W'(1);

      if (estado == SELECCION) begin
        cnt_bits <= '0;
      end else if (tick_subida) begin
        cnt_bits <= cnt_bits + BIT_W'(1);
        trama    <= {trama[FRAME_BITS-2:0], spi.sensor_miso};
      end

      if (estado == FIN) begin
        if (trama_valida(trama[TRAMA_W-1:0])) begin
          temp_salida       <= TEMP_W'(trama[TEMP_MSB:TEMP_LSB]);
          temp_valida       <= 1'b1;
          error_sensor      <= 1'b0;
          contador_muestras <= contador_muestras + 16'd1;
        end else begin
          error_sensor <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_monitoreo_sensor_lector.sv
// tb/tb_monitoreo_sensor_lector.sv - directed bench for monitoreo_sensor_lector
module tb_monitoreo_sensor_lector;
  localparam int PERIODO = 1000;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        habilitar;
  logic [9:0]  temp_salida;
  logic        temp_valida;
  logic        error_sensor;
  logic [15:0] contador_muestras;

  monitoreo_sensor_lector_if spi();

  monitoreo_sensor_lector dut (
    .clk               (clk),
    .arst_n            (arst_n),
    .habilitar         (habilitar),
    .spi               (spi),
    .temp_salida       (temp_salida),
    .temp_valida       (temp_valida),
    .error_sensor      (error_sensor),
    .contador_muestras (contador_muestras)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errores = 0;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s obs=%0d esp=%0d", tag, obs, esp);
    end
  endtask

  function automatic logic [15:0] armar(input logic [9:0] temp, input logic marca, input logic flip);
    logic [15:0] t;
    t    = {marca, temp, 4'b0000, 1'b0};
    t[0] = (^t) ^ flip;
    return t;
  endfunction

  int ciclo = 0;
  always @(posedge clk) ciclo++;

  int n_caidas = 0, ultima_caida = 0, previa_caida = 0, n_fin = 0, ciclo_sub_cs = 0;
  always @(negedge spi.sensor_cs_n) begin
    previa_caida = ultima_caida;
    ultima_caida = ciclo;
    n_caidas++;
  end
  always @(posedge spi.sensor_cs_n) begin
    ciclo_sub_cs = ciclo;
    n_fin++;
  end

  int n_validas = 0, ultima_lat = -1, n_dobles = 0;
  logic valida_prev = 1'b0;
  always @(negedge clk) begin
    if (temp_valida === 1'b1) begin
      n_validas++;
      ultima_lat = ciclo - ciclo_sub_cs;
      if (valida_prev) n_dobles++;
    end
    valida_prev = (temp_valida === 1'b1);
  end

  // Sensor model: presents bit 15 on cs_n fall, then the next bit after each sclk rise.
  logic [15:0] trama_tx = 16'h0;
  int n_sub = 0;
  always @(negedge spi.sensor_cs_n or posedge spi.sensor_sclk) begin
    if (spi.sensor_sclk === 1'b1) n_sub = n_sub + 1;
    else                          n_sub = 0;
    spi.sensor_miso = (n_sub < 16) ? trama_tx[15 - n_sub] : 1'b0;
  end

  task automatic esperar_fin(input string tag);
    int  inicio;
    bit  visto;
    inicio = n_fin;
    visto  = 1'b0;
    for (int n = 0; n < 3000 && !visto; n++) begin
      @(negedge clk);
      visto = (n_fin != inicio);
    end
    if (!visto) comprobar({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic trama_buena(input string tag, input logic [9:0] temp, input logic [15:0] cnt);
    int v0;
    v0 = n_validas;
    esperar_fin(tag);
    comprobar({tag, "_temp"}, temp_salida, temp);
    comprobar({tag, "_cnt"}, contador_muestras, cnt);
    comprobar({tag, "_err"}, error_sensor, 0);
    comprobar({tag, "_pulsos"}, n_validas - v0, 1);
    comprobar({tag, "_lat"}, ultima_lat, 1);
  endtask

  task automatic trama_mala(input string tag, input logic [9:0] temp, input logic [15:0] cnt);
    int v0;
    v0 = n_validas;
    esperar_fin(tag);
    comprobar({tag, "_temp"}, temp_salida, temp);
    comprobar({tag, "_cnt"}, contador_muestras, cnt);
    comprobar({tag, "_err"}, error_sensor, 1);
    comprobar({tag, "_pulsos"}, n_validas - v0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=%0d esp=%0d", ciclo, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ciclo_rel;
    int c0;
    arst_n    = 1'b0;
    habilitar = 1'b0;
    trama_tx  = armar(10'd220, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    comprobar("rst_cs_n", spi.sensor_cs_n, 1);
    comprobar("rst_sclk", spi.sensor_sclk, 0);
    comprobar("rst_temp", temp_salida, 220);
    comprobar("rst_valida", temp_valida, 0);
    comprobar("rst_err", error_sensor, 0);
    comprobar("rst_cnt", contador_muestras, 0);

    habilitar = 1'b1;
    arst_n    = 1'b1;
    ciclo_rel = ciclo;
    trama_buena("t220", 10'd220, 16'd1);
    comprobar("t220_caida", ultima_caida - ciclo_rel, 1);
    comprobar("t220_sclk_subidas", n_sub, 16);

    trama_tx = armar(10'd179, 1'b0, 1'b0);
    trama_buena("t179", 10'd179, 16'd2);
    comprobar("t179_periodo", ultima_caida - previa_caida, PERIODO);

    trama_tx = armar(10'd260, 1'b0, 1'b0);
    trama_buena("t260", 10'd260, 16'd3);
    comprobar("t260_periodo", ultima_caida - previa_caida, PERIODO);

    trama_tx = armar(10'd300, 1'b0, 1'b1);
    trama_mala("paridad", 10'd260, 16'd3);

    trama_tx = armar(10'd250, 1'b0, 1'b0);
    trama_buena("t250", 10'd250, 16'd4);

    trama_tx = armar(10'd100, 1'b1, 1'b0);
    trama_mala("marca", 10'd250, 16'd4);

    trama_tx = armar(10'd1023, 1'b0, 1'b0);
    trama_mala("descon", 10'd250, 16'd4);

    trama_tx = armar(10'd200, 1'b0, 1'b0);
    begin
      bit visto;
      visto = 1'b0;
      for (int n = 0; n < 3000 && !visto; n++) begin
        @(negedge clk);
        visto = (spi.sensor_cs_n === 1'b0) && (n_sub == 8);
      end
      if (!visto) comprobar("hab8_timeout", 0, 1);
    end
    habilitar = 1'b0;
    trama_buena("hab_off", 10'd200, 16'd5);
    c0 = n_caidas;
    repeat (3 * PERIODO) @(negedge clk);
    comprobar("hab_off_sin_caidas", n_caidas - c0, 0);

    trama_tx  = armar(10'd400, 1'b0, 1'b0);
    habilitar = 1'b1;
    begin
      bit visto;
      visto = 1'b0;
      for (int n = 0; n < 3000 && !visto; n++) begin
        @(negedge clk);
        visto = (spi.sensor_cs_n === 1'b0) && (n_sub == 5);
      end
      if (!visto) comprobar("rst5_timeout", 0, 1);
    end
    arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    comprobar("rst5_cs_n", spi.sensor_cs_n, 1);
    comprobar("rst5_sclk", spi.sensor_sclk, 0);
    comprobar("rst5_temp", temp_salida, 220);
    comprobar("rst5_cnt", contador_muestras, 0);
    trama_tx = armar(10'd150, 1'b0, 1'b0);
    arst_n   = 1'b1;
    trama_buena("t150", 10'd150, 16'd1);
    comprobar("t150_sclk_subidas", n_sub, 16);

    comprobar("valida_doble", n_dobles, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errores);
    $finish;
  end
endmodule
